// File: rtl/mips_sim_ctrl.sv
// mips_sim_ctrl: holds a core in reset, runs it, and stops on a repeated-PC halt or a cycle-budget timeout.
module mips_sim_ctrl #(
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES   = 100000,
   parameter int HALT_REPEAT  = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   input  logic             pc_valid,
   input  logic             wb_en,
   output logic             cpu_reset,
   output logic             running,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] wb_count
);
   typedef enum logic [1:0] {HOLD, RUN, HALTED, TIMEOUT} state_t;
   state_t           state_q, state_d;
   logic [7:0]       hold_q, hold_d, hold_nx, rep_q, rep_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, wb_q, wb_d;
   logic [31:0]      last_pc_q, last_pc_d;
   logic             same, halt;
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cyc_d     = cyc_q;
      wb_d      = wb_q;
      last_pc_d = last_pc_q;
      rep_d     = rep_q;
      hold_nx   = hold_q + 8'd1;
      same      = pc_valid && pc == last_pc_q && rep_q != 8'd0;
      halt      = same && rep_q + 8'd1 == 8'(HALT_REPEAT);
      if (state_q == HOLD) begin
         hold_d  = hold_nx == 8'(RESET_CYCLES) ? 8'd0 : hold_nx;
         state_d = hold_nx == 8'(RESET_CYCLES) ? RUN : HOLD;
      end else if (state_q == RUN) begin
         cyc_d     = cyc_q + CNT_W'(1);
         wb_d      = wb_q + CNT_W'(wb_en && !(&wb_q));
         last_pc_d = pc_valid ? pc : last_pc_q;
         rep_d     = !pc_valid ? rep_q : same ? rep_q + 8'd1 : 8'd1;
         // a halt on the budget's final edge still counts as a clean halt
         state_d   = halt ? HALTED : cyc_d == CNT_W'(MAX_CYCLES) ? TIMEOUT : RUN;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HOLD;
         hold_q    <= '0;
         cyc_q     <= '0;
         wb_q      <= '0;
         last_pc_q <= '0;
         rep_q     <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cyc_q     <= cyc_d;
         wb_q      <= wb_d;
         last_pc_q <= last_pc_d;
         rep_q     <= rep_d;
      end
   end
   assign cpu_reset   = state_q == HOLD || state_q == TIMEOUT;
   assign running     = state_q == RUN;
   assign done        = state_q == HALTED || state_q == TIMEOUT;
   assign timed_out   = state_q == TIMEOUT;
   assign cycle_count = cyc_q;
   assign wb_count    = wb_q;
endmodule
